// File: rtl/int_res_rd_streamer_pkg.sv
// Shared types for the intermediate-results read streamer: memory address/data
// types, read width/format selectors and the streamer state encoding.
package int_res_rd_streamer_pkg;

    localparam int INT_RES_ADDR_W = 8;
    localparam int COMP_FX_W      = 32;

    typedef logic [INT_RES_ADDR_W-1:0]  IntResAddr_t;
    typedef logic signed [COMP_FX_W-1:0] CompFx_t;

    typedef enum logic {
        SINGLE_WIDTH = 1'b0,
        DOUBLE_WIDTH = 1'b1
    } DataWidth_t;

    typedef enum logic [2:0] {
        INT_RES_SW_FX_1_X = 3'd0,
        INT_RES_SW_FX_2_X = 3'd1,
        INT_RES_SW_FX_5_X = 3'd2,
        INT_RES_SW_FX_6_X = 3'd3,
        INT_RES_DW_FX     = 3'd4
    } FxFormatIntRes_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } StreamerState_e;

    // Integer bits of a single-width word; the rest of the 16-bit word is fraction.
    function automatic int unsigned fx_int_bits(input FxFormatIntRes_t f);
        case (f)
            INT_RES_SW_FX_1_X: return 32'd1;
            INT_RES_SW_FX_2_X: return 32'd2;
            INT_RES_SW_FX_5_X: return 32'd5;
            INT_RES_SW_FX_6_X: return 32'd6;
            default:           return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/int_res_rd_streamer_if.sv
// Memory read port plus the valid/ready output stream of the read streamer.
interface int_res_rd_streamer_if;
    import int_res_rd_streamer_pkg::*;

    logic            mem_rd_en;
    IntResAddr_t     mem_rd_addr;
    DataWidth_t      mem_rd_data_width;
    FxFormatIntRes_t mem_rd_format;
    CompFx_t         mem_rd_data;

    logic            out_valid;
    logic            out_ready;
    CompFx_t         out_data;
    logic            out_last;

    modport master (
        output mem_rd_en, mem_rd_addr, mem_rd_data_width, mem_rd_format,
        input  mem_rd_data,
        output out_valid, out_data, out_last,
        input  out_ready
    );

    modport slave (
        input  mem_rd_en, mem_rd_addr, mem_rd_data_width, mem_rd_format,
        output mem_rd_data,
        input  out_valid, out_data, out_last,
        output out_ready
    );

endinterface

// File: rtl/int_res_rd_streamer_stream_fifo.sv
// Circular buffer with occupancy count and a one-bit "last" sideband per entry.
// Head outputs are forced to zero while the buffer is empty.
module int_res_rd_streamer_stream_fifo #(
    parameter int  DEPTH = 3,
    parameter int  W     = 32,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             push_last,
    input  logic             pop,
    output logic [W-1:0]     head_data,
    output logic             head_last,
    output logic [CNT_W-1:0] cnt,
    output logic             valid
);

    logic [W-1:0]     data_r [DEPTH];
    logic [DEPTH-1:0] last_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] cnt_r;
    logic             pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    assign pop_s = pop && (cnt_r != '0);
    assign cnt   = cnt_r;

    // Storage, pointers and occupancy; push and pop together leave the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_r[i] <= '0;
            end
            last_r   <= '0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
        end else begin
            if (push) begin
                data_r[wr_ptr_r] <= push_data;
                last_r[wr_ptr_r] <= push_last;
                wr_ptr_r         <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push, pop_s})
                2'b10:   cnt_r <= cnt_r + CNT_W'(1);
                2'b01:   cnt_r <= cnt_r - CNT_W'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Head entry presentation.
    always_comb begin
        valid = (cnt_r != '0);
        if (valid) begin
            head_data = data_r[rd_ptr_r];
            head_last = last_r[rd_ptr_r];
        end else begin
            head_data = '0;
            head_last = 1'b0;
        end
    end

endmodule

// File: rtl/int_res_rd_streamer.sv
// Strided read sequencer for the intermediate-results memory: issues reads under
// a credit limit, absorbs the one-cycle read latency and streams CompFx_t elements.
module int_res_rd_streamer
    import int_res_rd_streamer_pkg::*;
#(
    parameter int BUF_DEPTH = 3,
    parameter int LEN_W     = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  IntResAddr_t          base_addr,
    input  IntResAddr_t          stride,
    input  logic [LEN_W-1:0]     len,
    input  DataWidth_t           data_width,
    input  FxFormatIntRes_t      format,
    output logic                 busy,
    output logic                 done,
    int_res_rd_streamer_if.master bus
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    StreamerState_e  state_r;
    IntResAddr_t     cur_addr_r;
    IntResAddr_t     stride_r;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] n_iss_r;
    DataWidth_t      dw_r;
    FxFormatIntRes_t fmt_r;
    logic            inflight_r;
    logic            inflight_last_r;
    logic            busy_r;
    logic            done_r;

    logic [CNT_W-1:0] fifo_cnt_s;
    logic [CNT_W:0]   credit_sum_s;
    logic             issue_s;
    logic             last_issue_s;
    logic             fifo_valid_s;
    logic [$bits(CompFx_t)-1:0] head_data_s;
    logic             head_last_s;
    logic             pop_s;

    assign busy = busy_r;
    assign done = done_r;

    // Credit check on registered occupancy and in-flight read only, so out_ready never reaches mem_rd_en.
    always_comb begin
        credit_sum_s = {1'b0, fifo_cnt_s} + {{CNT_W{1'b0}}, inflight_r};
        last_issue_s = ((n_iss_r + LEN_W'(1)) == len_r);
        if ((state_r == RUN) && (credit_sum_s < (CNT_W + 1)'(BUF_DEPTH))) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Memory read port: pure decode of registered state, job fields zeroed when idle.
    always_comb begin
        if (issue_s) begin
            bus.mem_rd_en         = 1'b1;
            bus.mem_rd_addr       = cur_addr_r;
            bus.mem_rd_data_width = dw_r;
            bus.mem_rd_format     = fmt_r;
        end else begin
            bus.mem_rd_en         = 1'b0;
            bus.mem_rd_addr       = '0;
            bus.mem_rd_data_width = DataWidth_t'(1'b0);
            bus.mem_rd_format     = FxFormatIntRes_t'(3'd0);
        end
    end

    // Job sequencing: latch on start, issue strided reads, wait for the buffer to drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= IDLE;
            cur_addr_r      <= '0;
            stride_r        <= '0;
            len_r           <= '0;
            n_iss_r         <= '0;
            dw_r            <= SINGLE_WIDTH;
            fmt_r           <= INT_RES_SW_FX_1_X;
            inflight_r      <= 1'b0;
            inflight_last_r <= 1'b0;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
        end else begin
            done_r          <= 1'b0;
            inflight_r      <= issue_s;
            inflight_last_r <= issue_s && last_issue_s;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        cur_addr_r <= base_addr;
                        stride_r   <= stride;
                        len_r      <= len;
                        dw_r       <= data_width;
                        fmt_r      <= format;
                        n_iss_r    <= '0;
                        if (len != '0) begin
                            state_r <= RUN;
                            busy_r  <= 1'b1;
                        end else begin
                            done_r  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issue_s) begin
                        cur_addr_r <= cur_addr_r + stride_r;
                        n_iss_r    <= n_iss_r + LEN_W'(1);
                        if (last_issue_s) begin
                            state_r <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // inflight_r covers the push still pending from the final read.
                    if ((fifo_cnt_s == '0) && !inflight_r) begin
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign pop_s = fifo_valid_s && bus.out_ready;

    int_res_rd_streamer_stream_fifo #(
        .DEPTH (BUF_DEPTH),
        .W     ($bits(CompFx_t))
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_r),
        .push_data (bus.mem_rd_data),
        .push_last (inflight_last_r),
        .pop       (pop_s),
        .head_data (head_data_s),
        .head_last (head_last_s),
        .cnt       (fifo_cnt_s),
        .valid     (fifo_valid_s)
    );

    assign bus.out_valid = fifo_valid_s;
    assign bus.out_data  = head_data_s;
    assign bus.out_last  = head_last_s;

endmodule

// File: tb/tb_int_res_rd_streamer.sv
// Scoreboard bench for int_res_rd_streamer with a behavioural one-cycle-latency
// intermediate-results memory of 16-bit words.
module tb_int_res_rd_streamer;
    import int_res_rd_streamer_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    IntResAddr_t     base_addr;
    IntResAddr_t     stride;
    logic [9:0]      len;
    DataWidth_t      data_width;
    FxFormatIntRes_t format;
    logic            busy;
    logic            done;

    int_res_rd_streamer_if ifc ();

    int_res_rd_streamer #(.BUF_DEPTH(3), .LEN_W(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .stride     (stride),
        .len        (len),
        .data_width (data_width),
        .format     (format),
        .busy       (busy),
        .done       (done),
        .bus        (ifc)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int done_cnt = 0;
    int valid_cnt = 0;
    int pop_cnt = 0;
    int rd_cnt = 0;
    int max_cnt = 0;
    logic ready_rand = 1'b0;
    logic stall_prev = 1'b0;
    logic [32:0] prev_head;
    logic [15:0] mem_words [256];
    IntResAddr_t rd_log [256];
    logic [32:0] exp_q [$];
    logic [31:0] dw_vals [4] = '{32'h0003_8000, 32'hFFFE_4000, 32'h1234_5678, 32'h8000_0001};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic CompFx_t mem_model(input IntResAddr_t a, input DataWidth_t w, input FxFormatIntRes_t f);
        logic [31:0] ext;
        if (w == DOUBLE_WIDTH) begin
            return {mem_words[a + 8'd1], mem_words[a]};
        end
        ext = {{16{mem_words[a][15]}}, mem_words[a]};
        return ext << fx_int_bits(f);
    endfunction

    // Memory: data valid the cycle after mem_rd_en; every issued address is logged.
    always @(posedge clk) begin
        if (ifc.mem_rd_en) begin
            ifc.mem_rd_data      <= mem_model(ifc.mem_rd_addr, ifc.mem_rd_data_width, ifc.mem_rd_format);
            rd_log[rd_cnt[7:0]]  <= ifc.mem_rd_addr;
            rd_cnt               <= rd_cnt + 1;
        end
    end

    // Consumer ready: held high, or random while backpressure is exercised.
    always @(posedge clk) begin
        #1;
        ifc.out_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output monitor: scoreboard pops, stall stability, event counters.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (ifc.out_valid) valid_cnt++;
        if (int'(dut.fifo_cnt_s) > max_cnt) max_cnt = int'(dut.fifo_cnt_s);
        if (stall_prev) begin
            chk("stall_hold", {ifc.out_valid, ifc.out_last, ifc.out_data}, {1'b1, prev_head});
        end
        if (ifc.out_valid && ifc.out_ready) begin
            pop_cnt++;
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_pop", 64'(exp_q.size()), 64'd1);
            end else begin
                chk("sb_data", {ifc.out_last, ifc.out_data}, exp_q.pop_front());
            end
        end
        stall_prev = ifc.out_valid && !ifc.out_ready;
        prev_head  = {ifc.out_last, ifc.out_data};
    end

    task automatic preload_contig();
        for (int k = 0; k < 16; k++) begin
            mem_words[k] = 16'(k * 512);   // k*0.25 in 5.11 format
        end
    endtask

    task automatic push_contig(input int n);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({1'(k == n - 1), 32'(k * 16384)});   // k*0.25 in 16.16
        end
    endtask

    task automatic start_job(input IntResAddr_t b, input IntResAddr_t s, input int n,
                             input DataWidth_t w, input FxFormatIntRes_t f);
        @(posedge clk); #1;
        base_addr = b; stride = s; len = 10'(n); data_width = w; format = f; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic finish_job(input string tag, input int d0, input int r0, input int p0,
                              input int n, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_cnt > d0) break;
        end
        if (i == budget) chk({tag, "_done_timeout"}, 64'd0, 64'd1);
        repeat (3) @(negedge clk);
        chk({tag, "_done_once"}, 64'(done_cnt - d0), 64'd1);
        chk({tag, "_busy_low"}, 64'(busy), 64'd0);
        chk({tag, "_pops"}, 64'(pop_cnt - p0), 64'(n));
        chk({tag, "_reads"}, 64'(rd_cnt - r0), 64'(n));
        chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int d0, r0, p0, v0;
        rst_n = 1'b0; start = 1'b0; base_addr = '0; stride = '0; len = '0;
        data_width = SINGLE_WIDTH; format = INT_RES_SW_FX_5_X;
        for (int k = 0; k < 256; k++) mem_words[k] = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rd_en", 64'(ifc.mem_rd_en), 64'd0);
        chk("rst_rd_addr", 64'(ifc.mem_rd_addr), 64'd0);
        chk("rst_valid", 64'(ifc.out_valid), 64'd0);
        chk("rst_data_last", {ifc.out_last, ifc.out_data}, 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Contiguous single-width, ready high
        preload_contig(); push_contig(8);
        d0 = done_cnt; r0 = rd_cnt; p0 = pop_cnt;
        start_job(8'd0, 8'd1, 8, SINGLE_WIDTH, INT_RES_SW_FX_5_X);
        @(negedge clk);
        chk("first_rd_en", 64'(ifc.mem_rd_en), 64'd1);
        chk("first_rd_addr", 64'(ifc.mem_rd_addr), 64'd0);
        chk("busy_run", 64'(busy), 64'd1);
        @(negedge clk);
        chk("valid_not_early", 64'(ifc.out_valid), 64'd0);
        @(negedge clk);
        chk("first_valid", 64'(ifc.out_valid), 64'd1);
        finish_job("contig", d0, r0, p0, 8, 100);

        // Strided double-width
        for (int i = 0; i < 4; i++) begin
            mem_words[4 + 2 * i] = dw_vals[i][15:0];
            mem_words[5 + 2 * i] = dw_vals[i][31:16];
            exp_q.push_back({1'(i == 3), dw_vals[i]});
        end
        d0 = done_cnt; r0 = rd_cnt; p0 = pop_cnt;
        start_job(8'd4, 8'd2, 4, DOUBLE_WIDTH, INT_RES_DW_FX);
        finish_job("dw", d0, r0, p0, 4, 100);
        for (int i = 0; i < 4; i++) begin
            chk("dw_addr", 64'(rd_log[8'(r0 + i)]), 64'(4 + 2 * i));
        end

        // Random backpressure
        preload_contig(); push_contig(8);
        max_cnt = 0; ready_rand = 1'b1;
        d0 = done_cnt; r0 = rd_cnt; p0 = pop_cnt;
        start_job(8'd0, 8'd1, 8, SINGLE_WIDTH, INT_RES_SW_FX_5_X);
        finish_job("bp", d0, r0, p0, 8, 400);
        ready_rand = 1'b0;
        chk("bp_cnt_le_3", 64'(max_cnt <= 3), 64'd1);

        // len = 0
        @(posedge clk);
        d0 = done_cnt; r0 = rd_cnt; v0 = valid_cnt;
        start_job(8'd0, 8'd1, 0, SINGLE_WIDTH, INT_RES_SW_FX_5_X);
        @(negedge clk);
        chk("len0_done", 64'(done), 64'd1);
        @(negedge clk);
        chk("len0_done_pulse", 64'(done), 64'd0);
        repeat (5) @(negedge clk);
        chk("len0_no_reads", 64'(rd_cnt - r0), 64'd0);
        chk("len0_no_valid", 64'(valid_cnt - v0), 64'd0);
        chk("len0_done_once", 64'(done_cnt - d0), 64'd1);

        // Reset mid-job, then a normal len=2 job
        push_contig(16);
        d0 = done_cnt;
        start_job(8'd0, 8'd1, 16, SINGLE_WIDTH, INT_RES_SW_FX_5_X);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_rd_en", 64'(ifc.mem_rd_en), 64'd0);
        chk("mid_rst_valid", 64'(ifc.out_valid), 64'd0);
        chk("mid_rst_data_last", {ifc.out_last, ifc.out_data}, 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        exp_q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_rst_no_done", 64'(done_cnt - d0), 64'd0);
        push_contig(2);
        d0 = done_cnt; r0 = rd_cnt; p0 = pop_cnt;
        start_job(8'd0, 8'd1, 2, SINGLE_WIDTH, INT_RES_SW_FX_5_X);
        finish_job("post_rst", d0, r0, p0, 2, 100);

        // start while busy must not disturb the running job
        push_contig(8);
        d0 = done_cnt; r0 = rd_cnt; p0 = pop_cnt;
        start_job(8'd0, 8'd1, 8, SINGLE_WIDTH, INT_RES_SW_FX_5_X);
        repeat (3) @(posedge clk);
        #1 base_addr = 8'd100; stride = 8'd3; len = 10'd2; data_width = DOUBLE_WIDTH; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        finish_job("busy_start", d0, r0, p0, 8, 100);
        for (int i = 0; i < 8; i++) begin
            chk("busy_start_addr", 64'(rd_log[8'(r0 + i)]), 64'(i));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
